// File: rtl/wb_trace_capture.sv
// ---------------------------------------------------------------------------
// wb_trace_capture
//
// Passive Wishbone bus tracer. It snoops completed transfers (CYC & STB & ACK)
// and, once armed and triggered by an address match, records each transfer
// as an event in a small FIFO. A consumer drains the FIFO with a
// valid/ready handshake.
//
// Optional feature macro: WB_TRACE_TIMESTAMP_EN
//   When defined, a 32-bit free-running cycle counter is added. Each event
//   stores the counter value of its completing cycle, and that value is
//   presented on EVT_TSTAMP_OUT.
//
// Parameters
//   FIFO_DEPTH  event FIFO entries, power of two in 2..64
//   RD_DAT_DLY  reserved, has no effect on the logic
//
// Ports
//   CLK, RST_SYNC          clock, synchronous active-high reset
//   WB_CYC_IN/STB/WE/ACK   snooped Wishbone control
//   WB_ADR_IN, WB_SEL_IN   snooped address and byte selects
//   WB_DAT_WR_IN/RD_IN     snooped write and read data
//   ARM_IN, DISARM_IN      pulses: start waiting for trigger / stop capture
//   TRIG_ADR_IN/MASK_IN    trigger address and compare mask (1 = compared)
//   EVT_VALID_OUT/READY_IN event handshake (FIFO head)
//   EVT_RDWRB_OUT, EVT_SEL_OUT, EVT_ADR_OUT, EVT_WR_DAT_OUT, EVT_RD_DAT_OUT
//                          head event fields (all zero while FIFO empty)
//   EVT_TSTAMP_OUT         head event timestamp (only with the macro)
//   STATE_OUT              0 = IDLE, 1 = ARMED, 2 = CAPTURE
//   DROP_CNT_OUT           events lost to a full FIFO, saturating
//   FIFO_LVL_OUT           events currently held
// ---------------------------------------------------------------------------
module wb_trace_capture #(
    parameter int FIFO_DEPTH = 8,
    parameter int RD_DAT_DLY = 0
) (
    input  logic        CLK,
    input  logic        RST_SYNC,
    input  logic        WB_CYC_IN,
    input  logic        WB_STB_IN,
    input  logic        WB_WE_IN,
    input  logic        WB_ACK_IN,
    input  logic [31:0] WB_ADR_IN,
    input  logic [3:0]  WB_SEL_IN,
    input  logic [31:0] WB_DAT_WR_IN,
    input  logic [31:0] WB_DAT_RD_IN,
    input  logic        ARM_IN,
    input  logic        DISARM_IN,
    input  logic [31:0] TRIG_ADR_IN,
    input  logic [31:0] TRIG_MASK_IN,
    output logic        EVT_VALID_OUT,
    input  logic        EVT_READY_IN,
    output logic        EVT_RDWRB_OUT,
    output logic [3:0]  EVT_SEL_OUT,
    output logic [31:0] EVT_ADR_OUT,
    output logic [31:0] EVT_WR_DAT_OUT,
    output logic [31:0] EVT_RD_DAT_OUT,
`ifdef WB_TRACE_TIMESTAMP_EN
    output logic [31:0] EVT_TSTAMP_OUT,
`endif
    output logic [1:0]  STATE_OUT,
    output logic [15:0] DROP_CNT_OUT,
    output logic [6:0]  FIFO_LVL_OUT
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [6:0] DEPTH_LVL = 7'(FIFO_DEPTH);

    // RD_DAT_DLY is accepted for interface compatibility only; this empty
    // block is the sole place it is referenced.
    if (RD_DAT_DLY < 0) begin : g_rd_dat_dly_reserved
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    typedef struct packed {
`ifdef WB_TRACE_TIMESTAMP_EN
        logic [31:0] tstamp;
`endif
        logic        rdwrb;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] wr_dat;
        logic [31:0] rd_dat;
    } event_t;

    state_t          state;
    state_t          state_next;

    event_t          mem [FIFO_DEPTH];
    event_t          evt_in;
    event_t          evt_head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [6:0]      level;
    logic [15:0]     drop_cnt;

    logic            xfer_done;
    logic            trig_hit;
    logic            push_req;
    logic            push_ok;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            drop;

`ifdef WB_TRACE_TIMESTAMP_EN
    logic [31:0]     cycle_cnt;
`endif

    assign xfer_done  = WB_CYC_IN & WB_STB_IN & WB_ACK_IN;
    assign trig_hit   = (((WB_ADR_IN ^ TRIG_ADR_IN) & TRIG_MASK_IN) == 32'h0);
    assign fifo_empty = (level == 7'd0);
    assign fifo_full  = (level == DEPTH_LVL);
    assign pop        = ~fifo_empty & EVT_READY_IN;

    // DISARM blocks recording in its own cycle, including the trigger cycle.
    assign push_req = xfer_done & ~DISARM_IN &
                      ((state == CAPTURE) | ((state == ARMED) & trig_hit));

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push_req & (~fifo_full | pop);
    assign drop    = push_req & fifo_full & ~pop;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST_SYNC) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DISARM has priority over ARM and over a trigger; the
    // unused encoding falls back to IDLE through the default branch.
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE: begin
                if (ARM_IN && !DISARM_IN) begin
                    state_next = ARMED;
                end else begin
                    state_next = IDLE;
                end
            end
            ARMED: begin
                if (DISARM_IN) begin
                    state_next = IDLE;
                end else if (xfer_done && trig_hit) begin
                    state_next = CAPTURE;
                end else begin
                    state_next = ARMED;
                end
            end
            CAPTURE: begin
                if (DISARM_IN) begin
                    state_next = IDLE;
                end else begin
                    state_next = CAPTURE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef WB_TRACE_TIMESTAMP_EN
    // Free-running cycle counter; wraps naturally at 2^32.
    always_ff @(posedge CLK) begin
        if (RST_SYNC) begin
            cycle_cnt <= 32'h0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'h1;
        end
    end
`endif

    // Assemble the event from the completing cycle; the data bus that does
    // not belong to the transfer direction is recorded as zero.
    always_comb begin
        evt_in        = '0;
        evt_in.rdwrb  = ~WB_WE_IN;
        evt_in.sel    = WB_SEL_IN;
        evt_in.adr    = WB_ADR_IN;
        evt_in.wr_dat = WB_WE_IN ? WB_DAT_WR_IN : 32'h0;
        evt_in.rd_dat = WB_WE_IN ? 32'h0 : WB_DAT_RD_IN;
`ifdef WB_TRACE_TIMESTAMP_EN
        evt_in.tstamp = cycle_cnt;
`endif
    end

    // Event storage. Contents are not reset; the head is masked to zero
    // whenever the FIFO is empty, so stale entries never reach the outputs.
    always_ff @(posedge CLK) begin
        if (!RST_SYNC && push_ok) begin
            mem[wr_ptr] <= evt_in;
        end
    end

    // Pointers, occupancy and drop counter. Pointers wrap modulo the depth
    // because the depth is a power of two.
    always_ff @(posedge CLK) begin
        if (RST_SYNC) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= 7'd0;
            drop_cnt <= 16'h0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   level <= level + 7'd1;
                2'b01:   level <= level - 7'd1;
                default: level <= level;
            endcase
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'h1;
            end
        end
    end

    // Head of FIFO, forced to zero while empty.
    always_comb begin
        evt_head = '0;
        if (!fifo_empty) begin
            evt_head = mem[rd_ptr];
        end
    end

    assign EVT_VALID_OUT  = ~fifo_empty;
    assign EVT_RDWRB_OUT  = evt_head.rdwrb;
    assign EVT_SEL_OUT    = evt_head.sel;
    assign EVT_ADR_OUT    = evt_head.adr;
    assign EVT_WR_DAT_OUT = evt_head.wr_dat;
    assign EVT_RD_DAT_OUT = evt_head.rd_dat;
`ifdef WB_TRACE_TIMESTAMP_EN
    assign EVT_TSTAMP_OUT = evt_head.tstamp;
`endif
    assign STATE_OUT      = state;
    assign DROP_CNT_OUT   = drop_cnt;
    assign FIFO_LVL_OUT   = level;

endmodule

// File: tb/tb_wb_trace_capture.sv
// ---------------------------------------------------------------------------
// tb_wb_trace_capture
//
// Self-checking bench for wb_trace_capture (default depth 8). A behavioural
// model predicts state, drop count and the queue of expected events; the
// queue doubles as the scoreboard and is popped whenever the bench accepts an
// event from the DUT. A stimulus table carries hand-derived expected state,
// level and drop count; hand-written sequences cover overflow, full
// push+pop, reset with queued events and masked triggers.
// ---------------------------------------------------------------------------
module tb_wb_trace_capture;

    logic        CLK = 1'b0;
    logic        RST_SYNC;
    logic        WB_CYC_IN, WB_STB_IN, WB_WE_IN, WB_ACK_IN;
    logic [31:0] WB_ADR_IN;
    logic [3:0]  WB_SEL_IN;
    logic [31:0] WB_DAT_WR_IN, WB_DAT_RD_IN;
    logic        ARM_IN, DISARM_IN;
    logic [31:0] TRIG_ADR_IN, TRIG_MASK_IN;
    logic        EVT_VALID_OUT, EVT_READY_IN, EVT_RDWRB_OUT;
    logic [3:0]  EVT_SEL_OUT;
    logic [31:0] EVT_ADR_OUT, EVT_WR_DAT_OUT, EVT_RD_DAT_OUT;
`ifdef WB_TRACE_TIMESTAMP_EN
    logic [31:0] EVT_TSTAMP_OUT;
`endif
    logic [1:0]  STATE_OUT;
    logic [15:0] DROP_CNT_OUT;
    logic [6:0]  FIFO_LVL_OUT;

    always #5 CLK = ~CLK;

    wb_trace_capture #(.FIFO_DEPTH(8), .RD_DAT_DLY(0)) dut (
        .CLK            (CLK),
        .RST_SYNC       (RST_SYNC),
        .WB_CYC_IN      (WB_CYC_IN),
        .WB_STB_IN      (WB_STB_IN),
        .WB_WE_IN       (WB_WE_IN),
        .WB_ACK_IN      (WB_ACK_IN),
        .WB_ADR_IN      (WB_ADR_IN),
        .WB_SEL_IN      (WB_SEL_IN),
        .WB_DAT_WR_IN   (WB_DAT_WR_IN),
        .WB_DAT_RD_IN   (WB_DAT_RD_IN),
        .ARM_IN         (ARM_IN),
        .DISARM_IN      (DISARM_IN),
        .TRIG_ADR_IN    (TRIG_ADR_IN),
        .TRIG_MASK_IN   (TRIG_MASK_IN),
        .EVT_VALID_OUT  (EVT_VALID_OUT),
        .EVT_READY_IN   (EVT_READY_IN),
        .EVT_RDWRB_OUT  (EVT_RDWRB_OUT),
        .EVT_SEL_OUT    (EVT_SEL_OUT),
        .EVT_ADR_OUT    (EVT_ADR_OUT),
        .EVT_WR_DAT_OUT (EVT_WR_DAT_OUT),
        .EVT_RD_DAT_OUT (EVT_RD_DAT_OUT),
`ifdef WB_TRACE_TIMESTAMP_EN
        .EVT_TSTAMP_OUT (EVT_TSTAMP_OUT),
`endif
        .STATE_OUT      (STATE_OUT),
        .DROP_CNT_OUT   (DROP_CNT_OUT),
        .FIFO_LVL_OUT   (FIFO_LVL_OUT)
    );

    typedef struct {
        logic        rdwrb;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [31:0] rdat;
    } evt_t;

    typedef struct {
        logic        arm;
        logic        disarm;
        logic        cs;
        logic        ack;
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic [31:0] rdat;
        logic        ready;
        logic [1:0]  exp_state;
        logic [6:0]  exp_lvl;
        logic [15:0] exp_drop;
    } vec_t;

    evt_t sb[$];
    logic [1:0]  m_state;
    logic [15:0] m_drop;
    int n_checks = 0;
    int n_fails  = 0;

    // Single comparison with counting and FAIL reporting.
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare DUT status against the model; the head must match the oldest
    // expected event whenever the model holds one.
    task automatic checkOutput();
        check("state", 32'(STATE_OUT), 32'(m_state));
        check("level", 32'(FIFO_LVL_OUT), 32'(sb.size()));
        check("drop_cnt", 32'(DROP_CNT_OUT), 32'(m_drop));
        check("valid", 32'(EVT_VALID_OUT), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            check("head_rdwrb", 32'(EVT_RDWRB_OUT), 32'(sb[0].rdwrb));
            check("head_sel", 32'(EVT_SEL_OUT), 32'(sb[0].sel));
            check("head_adr", EVT_ADR_OUT, sb[0].adr);
            check("head_wdat", EVT_WR_DAT_OUT, sb[0].wdat);
            check("head_rdat", EVT_RD_DAT_OUT, sb[0].rdat);
        end
    endtask

    // Drive one cycle of stimulus, update the model and scoreboard, then
    // sample the DUT one time unit after the clock edge.
    task automatic applyStimulus(input vec_t v);
        evt_t e;
        logic complete, hit, push;
        ARM_IN       = v.arm;
        DISARM_IN    = v.disarm;
        WB_CYC_IN    = v.cs;
        WB_STB_IN    = v.cs;
        WB_ACK_IN    = v.ack;
        WB_WE_IN     = v.we;
        WB_ADR_IN    = v.adr;
        WB_SEL_IN    = v.sel;
        WB_DAT_WR_IN = v.wdat;
        WB_DAT_RD_IN = v.rdat;
        EVT_READY_IN = v.ready;

        complete = v.cs & v.ack;
        hit      = (((v.adr ^ TRIG_ADR_IN) & TRIG_MASK_IN) == 32'h0);
        push     = !v.disarm && complete && ((m_state == 2'd2) || ((m_state == 2'd1) && hit));

        if (v.ready && sb.size() != 0) begin
            e = sb.pop_front();
            check("pop_adr", EVT_ADR_OUT, e.adr);
            check("pop_wdat", EVT_WR_DAT_OUT, e.wdat);
            check("pop_rdat", EVT_RD_DAT_OUT, e.rdat);
        end
        if (push) begin
            e.rdwrb = ~v.we;
            e.sel   = v.sel;
            e.adr   = v.adr;
            e.wdat  = v.we ? v.wdat : 32'h0;
            e.rdat  = v.we ? 32'h0 : v.rdat;
            if (sb.size() < 8) sb.push_back(e);
            else if (m_drop != 16'hFFFF) m_drop++;
        end

        if (v.disarm) m_state = 2'd0;
        else if (m_state == 2'd0 && v.arm) m_state = 2'd1;
        else if (m_state == 2'd1 && complete && hit) m_state = 2'd2;

        @(posedge CLK);
        #1;
        checkOutput();
    endtask

    // Reset for one edge, optionally with a completing transfer on the bus.
    task automatic applyReset(input logic with_ack);
        RST_SYNC     = 1'b1;
        WB_CYC_IN    = with_ack;
        WB_STB_IN    = with_ack;
        WB_ACK_IN    = with_ack;
        WB_WE_IN     = 1'b1;
        WB_ADR_IN    = TRIG_ADR_IN;
        WB_DAT_WR_IN = 32'h5555_AAAA;
        EVT_READY_IN = with_ack;
        @(posedge CLK);
        #1;
        RST_SYNC  = 1'b0;
        WB_CYC_IN = 1'b0;
        WB_STB_IN = 1'b0;
        WB_ACK_IN = 1'b0;
        EVT_READY_IN = 1'b0;
        sb.delete();
        m_state = 2'd0;
        m_drop  = 16'h0;
        checkOutput();
        check("rst_adr", EVT_ADR_OUT, 32'h0);
        check("rst_wdat", EVT_WR_DAT_OUT, 32'h0);
        check("rst_rdat", EVT_RD_DAT_OUT, 32'h0);
        check("rst_sel", 32'(EVT_SEL_OUT), 32'h0);
        check("rst_rdwrb", 32'(EVT_RDWRB_OUT), 32'h0);
    endtask

    function automatic vec_t mk(input logic arm, input logic disarm, input logic cs,
                                input logic ack, input logic we, input logic [31:0] adr,
                                input logic [3:0] sel, input logic [31:0] wdat,
                                input logic [31:0] rdat, input logic ready,
                                input logic [1:0] es, input logic [6:0] el,
                                input logic [15:0] ed);
        vec_t v;
        v.arm = arm; v.disarm = disarm; v.cs = cs; v.ack = ack; v.we = we;
        v.adr = adr; v.sel = sel; v.wdat = wdat; v.rdat = rdat; v.ready = ready;
        v.exp_state = es; v.exp_lvl = el; v.exp_drop = ed;
        return v;
    endfunction

    vec_t tbl[$];
    vec_t v;

    initial begin
        RST_SYNC = 1'b1;
        ARM_IN = 0; DISARM_IN = 0; WB_CYC_IN = 0; WB_STB_IN = 0; WB_ACK_IN = 0;
        WB_WE_IN = 0; WB_ADR_IN = 0; WB_SEL_IN = 0; WB_DAT_WR_IN = 0; WB_DAT_RD_IN = 0;
        EVT_READY_IN = 0;
        TRIG_ADR_IN  = 32'h1F80_1070;
        TRIG_MASK_IN = 32'hFFFF_FFFF;
        m_state = 2'd0;
        m_drop  = 16'h0;

        //          arm dis cs ack we adr           sel    wdat          rdat          rdy  st lvl drop
        tbl.push_back(mk(0, 0, 1, 1, 1, 32'h1F801070, 4'hF, 32'h11111111, 32'h0,        0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,        4'hF, 32'h0,        32'h0,        0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 32'h00000100, 4'hF, 32'h0,        32'h12345678, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,        4'hF, 32'h0,        32'h0,        0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 32'h1F801070, 4'hF, 32'h0,        32'h0,        0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 32'h1F801070, 4'hF, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 32'h00000020, 4'h3, 32'hA5A5A5A5, 32'h77777777, 0, 2, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        4'hF, 32'h0,        32'h0,        1, 2, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 32'h00000024, 4'hF, 32'h24242424, 32'h0,        1, 2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        4'hF, 32'h0,        32'h0,        1, 2, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 32'h00000028, 4'hF, 32'h28282828, 32'h0,        1, 2, 1, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 32'h0000002C, 4'hF, 32'h2C2C2C2C, 32'h0,        0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,        4'hF, 32'h0,        32'h0,        0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 32'h1F801070, 4'hF, 32'h33333333, 32'h0,        0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        4'hF, 32'h0,        32'h0,        1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,        4'hF, 32'h0,        32'h0,        0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 32'h1F801070, 4'hF, 32'hCAFE0001, 32'h99999999, 0, 2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        4'hF, 32'h0,        32'h0,        1, 2, 0, 0));

        applyReset(1'b0);

        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            check($sformatf("vec%0d_state", i), 32'(STATE_OUT), 32'(tbl[i].exp_state));
            check($sformatf("vec%0d_level", i), 32'(FIFO_LVL_OUT), 32'(tbl[i].exp_lvl));
            check($sformatf("vec%0d_drop", i), 32'(DROP_CNT_OUT), 32'(tbl[i].exp_drop));
        end

        // Overflow: ten back-to-back writes with the consumer stalled.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(mk(0, 0, 1, 1, 1, 32'h1000 + 32'(i * 4), 4'hF,
                             32'hD000_0000 + 32'(i), 32'h0, 0, 2, 0, 0));
        end
        check("ovf_level", 32'(FIFO_LVL_OUT), 32'd8);
        check("ovf_drop", 32'(DROP_CNT_OUT), 32'd2);
        check("ovf_head_adr", EVT_ADR_OUT, 32'h1000);

        // Full FIFO with push and pop together: no drop, level holds.
        applyStimulus(mk(0, 0, 1, 1, 1, 32'h2000, 4'hF, 32'hE000_2000, 32'h0, 1, 2, 0, 0));
        check("fullpp_level", 32'(FIFO_LVL_OUT), 32'd8);
        check("fullpp_drop", 32'(DROP_CNT_OUT), 32'd2);
        check("fullpp_head_adr", EVT_ADR_OUT, 32'h1004);

        // Drain everything in order.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(mk(0, 0, 0, 0, 0, 32'h0, 4'hF, 32'h0, 32'h0, 1, 2, 0, 0));
        end
        check("drain_level", 32'(FIFO_LVL_OUT), 32'd0);
        check("drain_valid", 32'(EVT_VALID_OUT), 32'd0);

        // Queue three events, then reset with a transfer and pop in flight.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mk(0, 0, 1, 1, 0, 32'h3000 + 32'(i), 4'h1,
                             32'h0, 32'hB000_0000 + 32'(i), 0, 2, 0, 0));
        end
        check("pre_rst_level", 32'(FIFO_LVL_OUT), 32'd3);
        applyReset(1'b1);
        check("post_rst_level", 32'(FIFO_LVL_OUT), 32'd0);
        check("post_rst_drop", 32'(DROP_CNT_OUT), 32'd0);
        check("post_rst_state", 32'(STATE_OUT), 32'd0);

        // Masked trigger: only the upper half of the address is compared.
        TRIG_ADR_IN  = 32'h1F80_0000;
        TRIG_MASK_IN = 32'hFFFF_0000;
        applyStimulus(mk(1, 0, 0, 0, 0, 32'h0, 4'hF, 32'h0, 32'h0, 0, 0, 0, 0));
        applyStimulus(mk(0, 0, 1, 1, 0, 32'h1F81ABCD, 4'hF, 32'h0, 32'h01010101, 0, 0, 0, 0));
        check("mask_miss_state", 32'(STATE_OUT), 32'd1);
        applyStimulus(mk(0, 0, 1, 1, 0, 32'h1F80ABCD, 4'h8, 32'h0, 32'h02020202, 0, 0, 0, 0));
        check("mask_hit_state", 32'(STATE_OUT), 32'd2);
        check("mask_hit_level", 32'(FIFO_LVL_OUT), 32'd1);
        check("mask_hit_rdat", EVT_RD_DAT_OUT, 32'h02020202);
        applyStimulus(mk(0, 0, 0, 0, 0, 32'h0, 4'hF, 32'h0, 32'h0, 1, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/wb_trace_capture.md
WB_TRACE_CAPTURE -- requirements
Module: wb_trace_capture

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, event FIFO entries (power of two, 2..64).
REQ-002 Parameter RD_DAT_DLY, default 0, not used for capture timing; reserved, SHALL be ignored by logic.
REQ-003 CLK  in  1  single clock; all logic on rising edge.
REQ-004 RST_SYNC  in  1  synchronous, active-high reset.
REQ-005 WB_CYC_IN, WB_STB_IN, WB_WE_IN, WB_ACK_IN  in  1 each  snooped Wishbone master/slave control.
REQ-006 WB_ADR_IN  in  32  snooped address; WB_SEL_IN  in  4  byte selects.
REQ-007 WB_DAT_WR_IN  in  32  master write data; WB_DAT_RD_IN  in  32  slave read data.
REQ-008 ARM_IN  in  1  pulse: start waiting for trigger; DISARM_IN  in  1  pulse: stop capture.
REQ-009 TRIG_ADR_IN  in  32  trigger address; TRIG_MASK_IN  in  32  1 = bit compared.
REQ-010 EVT_VALID_OUT  out  1  event available; EVT_READY_IN  in  1  consumer accepts.
REQ-011 EVT_RDWRB_OUT  out  1 (1 = read); EVT_SEL_OUT  out  4; EVT_ADR_OUT  out  32; EVT_WR_DAT_OUT  out  32; EVT_RD_DAT_OUT  out  32.
REQ-012 STATE_OUT  out  2  FSM state; DROP_CNT_OUT  out  16  dropped events; FIFO_LVL_OUT  out  7  occupancy.

Function
REQ-013 Transfer completes in any cycle with WB_CYC_IN & WB_STB_IN & WB_ACK_IN all high; one event per such cycle, back-to-back allowed.
REQ-014 Event fields: RdWrB = ~WB_WE_IN, Sel, Adr, WrDat = WB_DAT_WR_IN (0 on reads), RdDat = WB_DAT_RD_IN (0 on writes), all sampled in the completing cycle.
REQ-015 FSM states IDLE=0, ARMED=1, CAPTURE=2; encoding 3 unused, SHALL return to IDLE.
REQ-016 IDLE -> ARMED on ARM_IN; ARMED -> CAPTURE on completing transfer with ((WB_ADR_IN ^ TRIG_ADR_IN) & TRIG_MASK_IN) == 0; that triggering transfer SHALL be captured.
REQ-017 ARMED or CAPTURE -> IDLE on DISARM_IN; DISARM_IN wins over ARM_IN and over a trigger in the same cycle; the transfer in that cycle is not captured.
REQ-018 ARM_IN in ARMED or CAPTURE SHALL be ignored; FIFO contents persist across IDLE.
REQ-019 Events pushed only in CAPTURE (and the trigger cycle); write latency: event visible on EVT_*_OUT one cycle after completing cycle when FIFO was empty.
REQ-020 EVT_*_OUT show FIFO head; pop when EVT_VALID_OUT & EVT_READY_IN; fields SHALL hold stable while EVT_VALID_OUT high and not popped.
REQ-021 Full FIFO, push without pop: event dropped, DROP_CNT_OUT increments, saturating at 16'hFFFF.
REQ-022 Full FIFO, push and pop same cycle: both accepted, no drop, level unchanged.
REQ-023 Empty FIFO, push and pop same cycle: no pop (VALID low), push accepted.
REQ-024 Read/write pointers wrap modulo FIFO_DEPTH; FIFO_LVL_OUT = entries held, 0..FIFO_DEPTH.

Reset
REQ-025 RST_SYNC high on a clock edge: STATE_OUT=IDLE, FIFO emptied, EVT_VALID_OUT=0, FIFO_LVL_OUT=0, DROP_CNT_OUT=0, all EVT data outputs 0.
REQ-026 Reset mid-transfer or mid-pop SHALL discard in-flight events; no event recorded for the reset cycle.

Configuration
REQ-027 Macro WB_TRACE_TIMESTAMP_EN defined: adds 32-bit free-running cycle counter (0 at reset, wraps) and output EVT_TSTAMP_OUT 32, counter value of completing cycle stored per event.
REQ-028 Macro undefined: no counter, no EVT_TSTAMP_OUT port; all other behaviour identical.

Verification
REQ-029 Reset, ARM_IN, write to 0x1F80_1070 with mask 0xFFFF_FFFF and TRIG_ADR 0x1F80_1070 -> STATE 2, one event RdWrB=0 Adr=0x1F801070 WrDat as driven RdDat=0.
REQ-030 ARMED, read to 0x0000_0100 then trigger read 0x1F80_1070 returning 0xDEAD_BEEF -> only trigger captured, RdDat=0xDEADBEEF, level 1.
REQ-031 CAPTURE, READY low, 10 back-to-back acks, depth 8 -> level 8, DROP_CNT 2, first 8 events in order on drain.
REQ-032 Full FIFO, READY high and ack same cycle -> no drop, level stays 8, order preserved.
REQ-033 DISARM_IN and trigger same cycle -> STATE 0, no event; RST_SYNC with 3 queued -> VALID 0, level 0, DROP_CNT 0.
REQ-034 With WB_TRACE_TIMESTAMP_EN, acks at cycles 5 and 9 after reset -> EVT_TSTAMP_OUT 5 then 9.
